// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg
// Shared widths and types for the Karatsuba multiplier arbiter.
//   OPERAND_W           : width of each multiplier operand
//   PRODUCT_W           : width of the full product
//   MUL_LATENCY_DEFAULT : default multiplier in_valid -> out_valid latency
//   MAX_ID_W            : widest requester id (up to 8 requesters)
//   rsp_entry_t         : one response FIFO entry {id, product}
package karatsuba_pkg;

  localparam int OPERAND_W           = 256;
  localparam int PRODUCT_W           = 512;
  localparam int MUL_LATENCY_DEFAULT = 8;
  localparam int MAX_ID_W            = 3;

  typedef struct packed {
    logic [MAX_ID_W-1:0]  id;
    logic [PRODUCT_W-1:0] product;
  } rsp_entry_t;

endpackage

// File: rtl/karatsuba_arbiter_if.sv
// karatsuba_arbiter_if
// Bundles the requester, multiplier and response handshakes of the arbiter.
//   req_valid/req_ready/req_x/req_y : per-requester operand ports (packed 256b per requester)
//   mul_in_valid/mul_x/mul_y        : issue side toward the multiplier
//   mul_out_valid/mul_p             : product return from the multiplier
//   rsp_valid/rsp_ready/rsp_id/rsp_p: buffered result toward the consumer
// Modports: slave = the arbiter, master = the surrounding fabric.
interface karatsuba_arbiter_if
  import karatsuba_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*OPERAND_W-1:0] req_x;
  logic [NUM_REQ*OPERAND_W-1:0] req_y;

  logic                 mul_in_valid;
  logic [OPERAND_W-1:0] mul_x;
  logic [OPERAND_W-1:0] mul_y;
  logic                 mul_out_valid;
  logic [PRODUCT_W-1:0] mul_p;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [PRODUCT_W-1:0] rsp_p;

  modport slave (
    input  req_valid, req_x, req_y, mul_out_valid, mul_p, rsp_ready,
    output req_ready, mul_in_valid, mul_x, mul_y, rsp_valid, rsp_id, rsp_p
  );

  modport master (
    output req_valid, req_x, req_y, mul_out_valid, mul_p, rsp_ready,
    input  req_ready, mul_in_valid, mul_x, mul_y, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/karatsuba_sync_fifo.sv
// karatsuba_sync_fifo
// Single-clock show-ahead FIFO; any DEPTH >= 2 (need not be a power of two).
//   clock, reset_n : clock, asynchronous active-low reset
//   push/push_data : write; accepted when not full, or when full and popping
//   pop/pop_data   : pop_data shows the head; reads 0 while empty
//   empty/full     : occupancy flags
//   count          : number of valid entries
module karatsuba_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gate the head so the outputs read as zero whenever nothing is stored.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/karatsuba_arbiter.sv
// karatsuba_arbiter
// Shares one fixed-latency, in-order, pipelined 256x256 multiplier among
// NUM_REQ requesters. Round-robin arbitration, one issue per cycle, requester
// ids tracked in a tag FIFO, results buffered in a show-ahead response FIFO.
// A credit counter admits a request only when a response slot is reserved.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus            : karatsuba_arbiter_if.slave (requester, multiplier, response sides)
//   mul_reset      : active-high multiplier reset, asserted while reset_n is low
//   err_tag        : sticky, product returned with no outstanding tag
// Optional: KARATSUBA_ARB_STATS_EN adds stat_issued / stat_stall saturating counters.
module karatsuba_arbiter
  import karatsuba_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int RSP_DEPTH   = 16,
  parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  karatsuba_arbiter_if.slave  bus,
  output logic                mul_reset,
  output logic                err_tag
`ifdef KARATSUBA_ARB_STATS_EN
  ,
  output logic [31:0]         stat_issued,
  output logic [31:0]         stat_stall
`endif
);

  localparam int CRED_W    = $clog2(RSP_DEPTH+1);
  // One extra slot: a push and the matching pop can land on the same edge.
  localparam int TAG_DEPTH = MUL_LATENCY + 1;
  localparam int TAG_CNT_W = $clog2(TAG_DEPTH+1);
  localparam int RSP_CNT_W = $clog2(RSP_DEPTH+1);

  logic [ID_W-1:0]      rr;
  logic [ID_W-1:0]      win_id;
  logic                 any_valid;
  logic                 accept;
  logic                 rsp_pop;
  logic [CRED_W-1:0]    credits;
  logic [OPERAND_W-1:0] sel_x;
  logic [OPERAND_W-1:0] sel_y;
  int                   idx;

  logic                 tag_pop;
  logic                 tag_empty;
  logic                 tag_full;
  logic [ID_W-1:0]      tag_head;
  logic [TAG_CNT_W-1:0] tag_count;

  rsp_entry_t           rsp_in;
  rsp_entry_t           rsp_head;
  logic                 rsp_empty;
  logic                 rsp_full;
  logic [RSP_CNT_W-1:0] rsp_count;
  logic                 unused_ok;

  assign mul_reset = ~reset_n;

  // First valid requester at or after rr, wrapping at NUM_REQ.
  always_comb begin
    any_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && bus.req_valid[ID_W'(idx)]) begin
        any_valid = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // reset_n gates readiness so nothing is granted while held in reset.
  assign accept  = any_valid && (credits != '0) && reset_n;
  assign rsp_pop = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    bus.req_ready = '0;
    sel_x         = '0;
    sel_y         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept && (win_id == ID_W'(i));
      if (win_id == ID_W'(i)) begin
        sel_x = bus.req_x[i*OPERAND_W +: OPERAND_W];
        sel_y = bus.req_y[i*OPERAND_W +: OPERAND_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr               <= '0;
      bus.mul_in_valid <= 1'b0;
      bus.mul_x        <= '0;
      bus.mul_y        <= '0;
    end else begin
      bus.mul_in_valid <= accept;
      if (accept) begin
        rr        <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
        bus.mul_x <= sel_x;
        bus.mul_y <= sel_y;
      end
    end
  end

  // Credits count free response slots not yet reserved by an in-flight product.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits <= CRED_W'(RSP_DEPTH);
    end else begin
      case ({accept, rsp_pop})
        2'b10:   if (credits != '0) credits <= credits - 1'b1;
        2'b01:   if (credits != CRED_W'(RSP_DEPTH)) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  assign tag_pop = bus.mul_out_valid && !tag_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                            err_tag <= 1'b0;
    else if (bus.mul_out_valid && tag_empty) err_tag <= 1'b1;
  end

  karatsuba_sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (win_id),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (tag_count)
  );

  always_comb begin
    rsp_in         = '0;
    rsp_in.id      = MAX_ID_W'(tag_head);
    rsp_in.product = bus.mul_p;
  end

  karatsuba_sync_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (tag_pop),
    .push_data (rsp_in),
    .pop       (bus.rsp_ready),
    .pop_data  (rsp_head),
    .empty     (rsp_empty),
    .full      (rsp_full),
    .count     (rsp_count)
  );

  assign bus.rsp_valid = !rsp_empty;
  assign bus.rsp_id    = rsp_head.id[ID_W-1:0];
  assign bus.rsp_p     = rsp_head.product;

  // Occupancy flags are redundant with credits; folded here to keep them visible.
  assign unused_ok = ^{tag_full, tag_count, rsp_full, rsp_count, rsp_head.id};

`ifdef KARATSUBA_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept && (stat_issued != '1)) stat_issued <= stat_issued + 1'b1;
      if (any_valid && (credits == '0) && (stat_stall != '1)) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_karatsuba_arbiter.sv
module tb_karatsuba_arbiter;
  import karatsuba_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int RSP_DEPTH   = 16;
  localparam int MUL_LATENCY = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic mul_reset;
  logic err_tag;
`ifdef KARATSUBA_ARB_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  karatsuba_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  karatsuba_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .RSP_DEPTH   (RSP_DEPTH),
    .MUL_LATENCY (MUL_LATENCY)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .mul_reset (mul_reset),
    .err_tag   (err_tag)
`ifdef KARATSUBA_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural multiplier: fixed latency, in order, cleared by mul_reset.
  logic                 pipe_v [MUL_LATENCY];
  logic [PRODUCT_W-1:0] pipe_p [MUL_LATENCY];
  logic                 inj_v;
  logic [PRODUCT_W-1:0] inj_p;

  always @(posedge clock or posedge mul_reset) begin
    if (mul_reset) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_p[i] <= '0;
      end
    end else begin
      pipe_v[0] <= bus.mul_in_valid;
      pipe_p[0] <= PRODUCT_W'(bus.mul_x) * PRODUCT_W'(bus.mul_y);
      for (int i = 1; i < MUL_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_p[i] <= pipe_p[i-1];
      end
    end
  end

  assign bus.mul_out_valid = pipe_v[MUL_LATENCY-1] | inj_v;
  assign bus.mul_p         = inj_v ? inj_p : pipe_p[MUL_LATENCY-1];

  task automatic check(input string tag, input logic [PRODUCT_W-1:0] obs,
                       input logic [PRODUCT_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;
    int npop;
    int bad;
    int rv;
    int ev;
    int e;

    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;
    inj_v         = 1'b0;
    inj_p         = '0;
    reset_n       = 1'b0;

    // ---------------- reset state
    repeat (3) tick();
    bus.req_valid = 4'b1111;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_mul_in_valid", bus.mul_in_valid, 0);
    check("rst_mul_x", bus.mul_x, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_p", bus.rsp_p, 0);
    check("rst_err_tag", err_tag, 0);
    check("rst_mul_reset", mul_reset, 1);
    check("rst_credits", dut.credits, RSP_DEPTH);
    check("rst_rr", dut.rr, 0);
    bus.req_valid = '0;
    tick();
    reset_n = 1'b1;

    // ---------------- single request from requester 2, 3*5
    bus.req_x[2*OPERAND_W +: OPERAND_W] = 256'd3;
    bus.req_y[2*OPERAND_W +: OPERAND_W] = 256'd5;
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    check("single_in_valid", bus.mul_in_valid, 1);
    check("single_mul_x", bus.mul_x, 3);
    check("single_mul_y", bus.mul_y, 5);
    check("single_credits", dut.credits, 15);
    check("single_rr", dut.rr, 3);
    lat = 1;
    while (!bus.rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
    check("single_latency", lat, 10);
    check("single_rsp_id", bus.rsp_id, 2);
    check("single_rsp_p", bus.rsp_p, 15);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("single_drained", bus.rsp_valid, 0);
    check("single_credits_back", dut.credits, RSP_DEPTH);

    // ---------------- round robin, all valid, rr starts at 3
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_x[i*OPERAND_W +: OPERAND_W] = OPERAND_W'(10 + i);
      bus.req_y[i*OPERAND_W +: OPERAND_W] = OPERAND_W'(i + 2);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      e = (3 + k) % NUM_REQ;
      if (bus.req_ready !== NUM_REQ'(1 << e)) bad++;
      tick();
    end
    bus.req_valid = '0;
    check("rr_grant_order", bad, 0);
    lat = 0;
    while (!bus.rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
    check("rr_rsp_arrived", bus.rsp_valid, 1);
    for (int k = 0; k < 8; k++) begin
      e = (3 + k) % NUM_REQ;
      check("rr_rsp_valid", bus.rsp_valid, 1);
      check("rr_rsp_id", bus.rsp_id, e);
      check("rr_rsp_p", bus.rsp_p, (10 + e) * (e + 2));
      tick();
    end
    check("rr_empty_after", bus.rsp_valid, 0);

    // ---------------- credit exhaustion, requester 0, consumer stalled
    bus.rsp_ready = 1'b0;
    bus.req_x[0 +: OPERAND_W] = 256'd7;
    bus.req_y[0 +: OPERAND_W] = 256'd9;
    bus.req_valid = 4'b0001;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.req_valid[0] && bus.req_ready[0]) acc++;
      tick();
    end
    #1;
    check("exhaust_accepts", acc, RSP_DEPTH);
    check("exhaust_ready", bus.req_ready, 0);
    check("exhaust_credits", dut.credits, 0);
    check("exhaust_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    #1;
    check("exhaust_ready_during_pop", bus.req_ready, 0);
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    check("exhaust_ready_restored", bus.req_ready, 4'b0001);
    check("exhaust_credits_one", dut.credits, 1);
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.req_valid[0] && bus.req_ready[0]) acc++;
      tick();
    end
    check("exhaust_one_more", acc, 1);
    check("exhaust_credits_zero", dut.credits, 0);

    // ---------------- same-cycle pop and accept at credits 1
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    check("same_pre_credits", dut.credits, 1);
    check("same_ready", bus.req_ready, 4'b0001);
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    check("same_credits_kept", dut.credits, 1);
    repeat (15) tick();
    bus.rsp_ready = 1'b1;
    npop = 0;
    bad  = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.rsp_valid) begin
        npop++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_p !== PRODUCT_W'(63)) bad++;
      end
      tick();
    end
    check("same_drain_count", npop, 15);
    check("same_drain_data", bad, 0);
    check("same_credits_full", dut.credits, RSP_DEPTH);

    // ---------------- stray multiplier output
    check("err_before", err_tag, 0);
    inj_v = 1'b1;
    inj_p = PRODUCT_W'(123);
    tick();
    inj_v = 1'b0;
    check("err_set", err_tag, 1);
    check("err_no_rsp", bus.rsp_valid, 0);
    repeat (3) tick();
    check("err_sticky", err_tag, 1);
    check("err_still_no_rsp", bus.rsp_valid, 0);
    check("err_credits", dut.credits, RSP_DEPTH);

    // ---------------- reset with five products in flight
    bus.req_valid = 4'b0001;
    repeat (5) tick();
    bus.req_valid = '0;
    check("flight_credits", dut.credits, RSP_DEPTH - 5);
    tick();
    tick();
    bus.req_valid = 4'b0001;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.req_ready, 0);
    check("mid_rst_in_valid", bus.mul_in_valid, 0);
    check("mid_rst_mul_x", bus.mul_x, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_err_tag", err_tag, 0);
    check("mid_rst_credits", dut.credits, RSP_DEPTH);
    check("mid_rst_rr", dut.rr, 0);
    bus.req_valid = '0;
    tick();
    reset_n = 1'b1;
    rv = 0;
    ev = 0;
    for (int k = 0; k < 25; k++) begin
      #1;
      if (bus.rsp_valid) rv++;
      if (err_tag) ev++;
      tick();
    end
    check("post_rst_no_rsp", rv, 0);
    check("post_rst_no_err", ev, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
